controller_sequencer: RTL and testbench
=======================================

// Module: controller_sequencer
// PURPOSE
//   SAP-1 control unit: a T-state ring counter plus an opcode decoder. Each cycle it issues
//   the control word (Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo) that drives PC, MAR, RAM, IR, A, B,
//   the adder/subtracter (Su/Eu) and the output register, and it stops the machine on HLT.
//   It is the initiator of the W-bus protocol; every other SAP-1 block responds to its strobes.
// PARAMETERS
//   OPC_W     4      opcode width (IR upper nibble)
//   OP_LDA    4'h0   load A from RAM[operand]
//   OP_ADD    4'h1   A <= A + RAM[operand]
//   OP_SUB    4'h2   A <= A - RAM[operand]
//   OP_OUT    4'hE   output register <= A
//   OP_HLT    4'hF   halt
//   SKIP_NOPS 0      1: return to T1 right after the last active T-state of each instruction
// PORTS
//   clk        in   1      system clock; all state changes on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   run        in   1      1: sequencer advances; 0: state held, all control outputs 0
//   ir_opcode  in   OPC_W  instruction register opcode field; valid from T4
//   t_state    out  6      one-hot T1..T6 (bit0 = T1)
//   halted     out  1      1 once HLT has executed; cleared only by reset
//   cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo  out 1 each  active-high control strobes
// BEHAVIOUR
//   Reset: t_state=6'b000001, halted=0. While rst_n=0, all strobes are 0.
//   Strobes are decoded combinationally from the registered t_state, ir_opcode, run and halted.
//   A responder acts on the rising edge that ends the cycle in which its strobe is high.
//   Gating: strobes are 0 when run=0 or halted=1. Held T-states never re-issue cp.
//   Control word per T-state (strobes not listed are 0):
//     T1: ep, lm                     (fetch address)
//     T2: cp                         (PC increment)
//     T3: ce, li                     (IR <= RAM)
//     T4: LDA/ADD/SUB: ei, lm | OUT: ea, lo | HLT: none | other opcode: none (NOP)
//     T5: LDA: ce, la | ADD/SUB: ce, lb | others: none
//     T6: ADD: eu, la (su=0) | SUB: eu, la, su=1 | others: none
//   su is 1 only in T6 of SUB. eu is 1 only in T6 of ADD/SUB.
//   Advance: when run=1 and halted=0, t_state rotates left each edge; T6 goes to T1.
//   SKIP_NOPS=1: next state is T1 after T5 for LDA, after T4 for OUT and undefined opcodes,
//     and after T6 for ADD/SUB. Cycles per instruction: LDA 5, ADD/SUB 6, OUT/NOP 4.
//   HLT: on the edge ending T4 with ir_opcode==OP_HLT (run=1), halted<=1 and t_state holds T4.
//     It stays halted regardless of run or ir_opcode until rst_n=0.
//   ir_opcode is sampled only in T4..T6. Changes during T1..T3 have no effect.
//   Async reset mid-instruction: state returns to T1 immediately and strobes go 0 at once.
//     The first edge after release executes T1 -> T2.
//   run deassert in any T-state: that state freezes and its strobes resume when run returns.
// TESTING
//   1 Reset release, run=1, opcode 0x1: t_state 01,02,04,08,10,20,01. Exact strobe set
//     per state: T4 ei+lm, T5 ce+lb, T6 eu+la with su=0.
//   2 Opcode 0x2 (SUB): same sequence as 0x1; T6 gives su=1, eu=1, la=1. su=0 in all other states.
//   3 Opcode 0xF: T4 shows no strobes. After that edge halted=1, t_state=08, all strobes 0
//     for 20 cycles even with run toggled. rst_n pulse -> t_state=01, halted=0.
//   4 run=0 in T2 for 5 cycles: t_state stays 02 and cp=0 throughout.
//     run=1 -> exactly one cycle of cp=1, then T3.
//   5 SKIP_NOPS=1 with program LDA, OUT, ADD, opcode 0x7: cycle counts 5, 4, 6, 4.
//     OUT T4 drives ea=1 and lo=1.
//   6 rst_n low in T5 of LDA: t_state=01 and ce=la=0 within the same cycle, before the next edge.

Source files
------------

// File: rtl/controller_sequencer_if.sv
// W-bus control interface of the SAP-1 sequencer: run/opcode in, T-state and strobes out.
// The master modport belongs to the sequencer, the slave modport to the responding datapath.
interface controller_sequencer_if #(
    parameter int OPC_W = 4
);
    logic             run;
    logic [OPC_W-1:0] ir_opcode;
    logic [5:0]       t_state;
    logic             halted;
    logic             cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    modport master (
        input  run, ir_opcode,
        output t_state, halted,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

    modport slave (
        output run, ir_opcode,
        input  t_state, halted,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: one-hot T1..T6 ring counter with opcode decode of the control word.
// Strobes are decoded from registered state so they drop immediately on async reset.
module controller_sequencer #(
    parameter int               OPC_W     = 4,
    parameter logic [OPC_W-1:0] OP_LDA    = 4'h0,
    parameter logic [OPC_W-1:0] OP_ADD    = 4'h1,
    parameter logic [OPC_W-1:0] OP_SUB    = 4'h2,
    parameter logic [OPC_W-1:0] OP_OUT    = 4'hE,
    parameter logic [OPC_W-1:0] OP_HLT    = 4'hF,
    parameter bit               SKIP_NOPS = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controller_sequencer_if.master bus
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    // Control word bit order: {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}
    localparam logic [11:0] W_CP = 12'h800;
    localparam logic [11:0] W_EP = 12'h400;
    localparam logic [11:0] W_LM = 12'h200;
    localparam logic [11:0] W_CE = 12'h100;
    localparam logic [11:0] W_LI = 12'h080;
    localparam logic [11:0] W_EI = 12'h040;
    localparam logic [11:0] W_LA = 12'h020;
    localparam logic [11:0] W_EA = 12'h010;
    localparam logic [11:0] W_SU = 12'h008;
    localparam logic [11:0] W_EU = 12'h004;
    localparam logic [11:0] W_LB = 12'h002;
    localparam logic [11:0] W_LO = 12'h001;

    tstate_e     state_r;
    logic        halted_r;
    logic [11:0] word_s;
    logic        is_mem_s;
    logic        is_alu_s;

    assign is_alu_s = (bus.ir_opcode == OP_ADD) || (bus.ir_opcode == OP_SUB);
    assign is_mem_s = (bus.ir_opcode == OP_LDA) || is_alu_s;

    // T-state ring advance, optional early return to T1, and sticky halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= T1;
            halted_r <= 1'b0;
        end else if (bus.run && !halted_r) begin
            case (state_r)
                T1: state_r <= T2;
                T2: state_r <= T3;
                T3: state_r <= T4;
                T4: begin
                    if (bus.ir_opcode == OP_HLT) begin
                        halted_r <= 1'b1;
                    end else if (SKIP_NOPS && !is_mem_s) begin
                        state_r <= T1;
                    end else begin
                        state_r <= T5;
                    end
                end
                T5: begin
                    if (SKIP_NOPS && (bus.ir_opcode == OP_LDA)) begin
                        state_r <= T1;
                    end else begin
                        state_r <= T6;
                    end
                end
                T6:      state_r <= T1;
                default: state_r <= T1;
            endcase
        end
    end

    // Control word decode, gated off while in reset, stopped or halted
    always_comb begin
        word_s = 12'h000;
        if (rst_n && bus.run && !halted_r) begin
            case (state_r)
                T1: word_s = W_EP | W_LM;
                T2: word_s = W_CP;
                T3: word_s = W_CE | W_LI;
                T4: begin
                    if (is_mem_s) begin
                        word_s = W_EI | W_LM;
                    end else if (bus.ir_opcode == OP_OUT) begin
                        word_s = W_EA | W_LO;
                    end else begin
                        word_s = 12'h000;
                    end
                end
                T5: begin
                    if (bus.ir_opcode == OP_LDA) begin
                        word_s = W_CE | W_LA;
                    end else if (is_alu_s) begin
                        word_s = W_CE | W_LB;
                    end else begin
                        word_s = 12'h000;
                    end
                end
                T6: begin
                    if (bus.ir_opcode == OP_ADD) begin
                        word_s = W_EU | W_LA;
                    end else if (bus.ir_opcode == OP_SUB) begin
                        word_s = W_EU | W_LA | W_SU;
                    end else begin
                        word_s = 12'h000;
                    end
                end
                default: word_s = 12'h000;
            endcase
        end else begin
            word_s = 12'h000;
        end
    end

    assign bus.t_state = state_r;
    assign bus.halted  = halted_r;
    assign {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
            bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo} = word_s;
endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: per-cycle expectations are queued from a T-state model
// and compared against two instances (plain and SKIP_NOPS=1) on the falling edge.
module tb_controller_sequencer;
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

    typedef struct {
        logic       run;
        logic [3:0] op;
        logic [5:0] t;
        logic [11:0] w;
        logic       h;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   sel = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    controller_sequencer_if bus0 ();
    controller_sequencer_if bus1 ();

    controller_sequencer #(.SKIP_NOPS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    controller_sequencer #(.SKIP_NOPS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    function automatic logic [11:0] word_of(int s);
        if (s == 0)
            return {bus0.cp, bus0.ep, bus0.lm, bus0.ce, bus0.li, bus0.ei,
                    bus0.la, bus0.ea, bus0.su, bus0.eu, bus0.lb, bus0.lo};
        return {bus1.cp, bus1.ep, bus1.lm, bus1.ce, bus1.li, bus1.ei,
                bus1.la, bus1.ea, bus1.su, bus1.eu, bus1.lb, bus1.lo};
    endfunction

    function automatic logic [5:0] t_of(int s);
        return (s == 0) ? bus0.t_state : bus1.t_state;
    endfunction

    function automatic logic h_of(int s);
        return (s == 0) ? bus0.halted : bus1.halted;
    endfunction

    task automatic drive(int s, logic r, logic [3:0] op);
        if (s == 0) begin
            bus0.run = r; bus0.ir_opcode = op;
        end else begin
            bus1.run = r; bus1.ir_opcode = op;
        end
    endtask

    task automatic push(logic r, logic [3:0] op, logic [5:0] t, logic [11:0] w, logic h);
        exp_t e;
        e.run = r; e.op = op; e.t = t; e.w = w; e.h = h;
        sb.push_back(e);
    endtask

    // Expected cycles of one instruction with run held high
    task automatic push_instr(logic [3:0] op, bit skip);
        logic [11:0] w4, w5, w6;
        bit mem, alu;
        alu = (op == 4'h1) || (op == 4'h2);
        mem = alu || (op == 4'h0);
        w4 = mem ? (EI | LM) : ((op == 4'hE) ? (EA | LO) : 12'h000);
        w5 = (op == 4'h0) ? (CE | LA) : (alu ? (CE | LB) : 12'h000);
        w6 = (op == 4'h1) ? (EU | LA) : ((op == 4'h2) ? (EU | LA | SU) : 12'h000);
        push(1'b1, op, 6'h01, EP | LM, 1'b0);
        push(1'b1, op, 6'h02, CP, 1'b0);
        push(1'b1, op, 6'h04, CE | LI, 1'b0);
        push(1'b1, op, 6'h08, w4, 1'b0);
        if (op == 4'hF || (skip && !mem)) return;
        push(1'b1, op, 6'h10, w5, 1'b0);
        if (skip && op == 4'h0) return;
        push(1'b1, op, 6'h20, w6, 1'b0);
    endtask

    task automatic drain(string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            drive(sel, e.run, e.op);
            #1;
            checks++;
            if (t_of(sel) !== e.t || word_of(sel) !== e.w || h_of(sel) !== e.h) begin
                failures++;
                $display("FAIL %s: got t_state=%b strobes=%h halted=%b, want t_state=%b strobes=%h halted=%b",
                         name, t_of(sel), word_of(sel), h_of(sel), e.t, e.w, e.h);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 4'h0);
        drive(1, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 4'h1);
        drive(1, 1'b1, 4'h1);
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (t_of(s) !== 6'h01 || h_of(s) !== 1'b0 || word_of(s) !== 12'h000) begin
                failures++;
                $display("FAIL reset[%0d]: got t_state=%b halted=%b strobes=%h, want 000001 0 000",
                         s, t_of(s), h_of(s), word_of(s));
            end
        end
        do_reset();
    endtask

    task automatic test_add();
        sel = 0;
        do_reset();
        push_instr(4'h1, 1'b0);
        push(1'b1, 4'h1, 6'h01, EP | LM, 1'b0);
        drain("add");
    endtask

    task automatic test_sub();
        sel = 0;
        do_reset();
        push_instr(4'h2, 1'b0);
        push(1'b1, 4'h2, 6'h01, EP | LM, 1'b0);
        drain("sub");
    endtask

    task automatic test_halt();
        sel = 0;
        do_reset();
        push_instr(4'hF, 1'b0);
        for (int i = 0; i < 20; i++)
            push(logic'(i % 2 == 0), 4'($urandom_range(0, 15)), 6'h08, 12'h000, 1'b1);
        drain("halt");
        rst_n = 1'b0;
        drive(0, 1'b0, 4'h0);
        #1;
        checks++;
        if (t_of(0) !== 6'h01 || h_of(0) !== 1'b0 || word_of(0) !== 12'h000) begin
            failures++;
            $display("FAIL halt_reset: got t_state=%b halted=%b strobes=%h, want 000001 0 000",
                     t_of(0), h_of(0), word_of(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 4'h0, 6'h01, EP | LM, 1'b0);
        push(1'b1, 4'h0, 6'h02, CP, 1'b0);
        drain("halt_restart");
    endtask

    task automatic test_run_hold();
        sel = 0;
        do_reset();
        push(1'b1, 4'h0, 6'h01, EP | LM, 1'b0);
        for (int i = 0; i < 5; i++) push(1'b0, 4'h0, 6'h02, 12'h000, 1'b0);
        push(1'b1, 4'h0, 6'h02, CP, 1'b0);
        push(1'b1, 4'h0, 6'h04, CE | LI, 1'b0);
        drain("run_hold");
    endtask

    task automatic test_skip_nops();
        logic [3:0] ops [4];
        int         want [4];
        int         cnt;
        ops  = '{4'h0, 4'hE, 4'h1, 4'h7};
        want = '{5, 4, 6, 4};
        sel = 1;
        do_reset();
        for (int i = 0; i < 4; i++) push_instr(ops[i], 1'b1);
        push(1'b1, 4'h0, 6'h01, EP | LM, 1'b0);
        drain("skip_seq");
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, ops[i]);
            cnt = 0;
            do begin
                @(negedge clk);
                #1;
                cnt++;
            end while (t_of(1) !== 6'h01 && cnt < 12);
            checks++;
            if (cnt != want[i]) begin
                failures++;
                $display("FAIL skip_cycles op=%h: got %0d cycles, want %0d", ops[i], cnt, want[i]);
            end
        end
        sel = 0;
    endtask

    task automatic test_async_reset();
        sel = 0;
        do_reset();
        push(1'b1, 4'h0, 6'h01, EP | LM, 1'b0);
        push(1'b1, 4'h0, 6'h02, CP, 1'b0);
        push(1'b1, 4'h0, 6'h04, CE | LI, 1'b0);
        push(1'b1, 4'h0, 6'h08, EI | LM, 1'b0);
        push(1'b1, 4'h0, 6'h10, CE | LA, 1'b0);
        drain("lda_to_t5");
        rst_n = 1'b0;
        #1;
        checks++;
        if (t_of(0) !== 6'h01 || bus0.ce !== 1'b0 || bus0.la !== 1'b0 || word_of(0) !== 12'h000) begin
            failures++;
            $display("FAIL async_reset: got t_state=%b strobes=%h, want 000001 000",
                     t_of(0), word_of(0));
        end
        #1;
        rst_n = 1'b1;
        push(1'b1, 4'h0, 6'h02, CP, 1'b0);
        push(1'b1, 4'h0, 6'h04, CE | LI, 1'b0);
        drain("after_async_reset");
    endtask

    initial begin
        drive(0, 1'b0, 4'h0);
        drive(1, 1'b0, 4'h0);
        test_reset();
        test_add();
        test_sub();
        test_halt();
        test_run_hold();
        test_skip_nops();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
